pl_run_ctrl: RTL

Run controller that sequences the pipelined CPU core through reset, execution and halt. It holds the core in reset for a fixed count and runs it until the `hlt` instruction retires or a cycle budget expires. It also accumulates cycle, stall and branch-prediction statistics for software readout and bench reporting. It sits between the top-level clock/reset and the core, gating the core's clock enable and driving its reset.

---
 rtl/pl_run_ctrl_pkg.sv | 23 ++
 rtl/pl_sat_counter.sv | 31 +++
 rtl/pl_run_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pl_run_ctrl_pkg.sv
// pl_run_ctrl_pkg: shared types and constants for the run controller.
//   run_state_t : controller FSM state encoding
//   CNT_W_DEF   : default width of the statistic counters
//   sat_ones()  : all-ones value for a given width (saturation limit)
package pl_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_RUN      = 3'd2,
    ST_DONE     = 3'd3,
    ST_TIMEOUT  = 3'd4
  } run_state_t;

  localparam int CNT_W_DEF = 32;

  // All-ones value of width w, returned right-aligned in 64 bits.
  function automatic logic [63:0] sat_ones(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pl_sat_counter.sv
// pl_sat_counter: saturating up-counter used for each run statistic.
//   input_clk : clock, rising edge
//   rst       : asynchronous active-low reset, clears q
//   clr       : synchronous clear (wins over inc)
//   inc       : add one, unless q is already all-ones
//   q         : count value
module pl_sat_counter
  import pl_run_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         input_clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONES = W'(sat_ones(W));

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != ONES)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pl_run_ctrl.sv
// pl_run_ctrl: sequences the pipelined core through reset hold, run and halt,
// and accumulates cycle / stall / branch-prediction statistics.
//   input_clk, rst            : clock and asynchronous active-low reset
//   start, abort              : run request / forced return to IDLE
//   hlt_retired, stall        : core status for the current cycle
//   br_valid, br_miss         : branch resolution (miss qualified by valid)
//   core_rst, core_clk_en     : reset and clock enable driven to the core
//   busy, done, timeout       : run status
//   cycles_consumed, StallCount, BranchPredictionCount,
//   BranchPredictionMissCount : saturating statistics
//   dbg_state                 : current FSM state, for observation only
// Optional feature: define RUN_CTRL_BRANCH_STATS_EN to build the two branch
// counters; otherwise the branch outputs are tied to 0.
//
// Handshake: start is a level request, accepted only on an edge where the FSM
// is in IDLE, DONE or TIMEOUT and abort is low; abort is accepted on any edge
// and beats every other event. All outputs decode registered state only.
module pl_run_ctrl
  import pl_run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 200000,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             input_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hlt_retired,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_miss,
  output logic             core_rst,
  output logic             core_clk_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles_consumed,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] BranchPredictionCount,
  output logic [CNT_W-1:0] BranchPredictionMissCount,
  output run_state_t       dbg_state
);

  run_state_t state, state_nxt;
  logic [7:0] hold;
  logic       start_ok;
  logic       run_inc;
  logic       last_cycle;

  assign start_ok = start && !abort &&
                    ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_TIMEOUT));
  // A RUN cycle is counted unless abort cancels it.
  assign run_inc    = (state == ST_RUN) && !abort;
  // This cycle's increment brings the count to the budget.
  assign last_cycle = (cycles_consumed == CNT_W'(MAX_CYCLES - 1));

  // State register
  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: if (start) state_nxt = ST_RST_HOLD;
        ST_RST_HOLD:                  if (hold == 8'd0) state_nxt = ST_RUN;
        ST_RUN: begin
          // hlt wins over the budget when both land on the same cycle.
          if (hlt_retired)     state_nxt = ST_DONE;
          else if (last_cycle) state_nxt = ST_TIMEOUT;
        end
        default:                      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    core_rst    = 1'b1;
    core_clk_en = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    case (state)
      ST_RST_HOLD: begin core_rst = 1'b1; core_clk_en = 1'b1; busy = 1'b1; end
      ST_RUN:      begin core_rst = 1'b0; core_clk_en = 1'b1; busy = 1'b1; end
      ST_DONE:     begin core_rst = 1'b0; done = 1'b1; end
      ST_TIMEOUT:  begin core_rst = 1'b0; timeout = 1'b1; end
      default:     begin core_rst = 1'b1; core_clk_en = 1'b0; end
    endcase
  end

  assign dbg_state = state;

  // Reset hold counter: loaded with RESET_CYCLES-1 so RST_HOLD lasts
  // exactly RESET_CYCLES cycles.
  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      hold <= 8'd0;
    end else if (start_ok) begin
      hold <= 8'(RESET_CYCLES - 1);
    end else if ((state == ST_RST_HOLD) && (hold != 8'd0)) begin
      hold <= hold - 8'd1;
    end
  end

  pl_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .input_clk (input_clk),
    .rst       (rst),
    .clr       (start_ok),
    .inc       (run_inc),
    .q         (cycles_consumed)
  );

  pl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .input_clk (input_clk),
    .rst       (rst),
    .clr       (start_ok),
    .inc       (run_inc && stall),
    .q         (StallCount)
  );

`ifdef RUN_CTRL_BRANCH_STATS_EN
  pl_sat_counter #(.W(CNT_W)) u_br_cnt (
    .input_clk (input_clk),
    .rst       (rst),
    .clr       (start_ok),
    .inc       (run_inc && br_valid),
    .q         (BranchPredictionCount)
  );

  pl_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .input_clk (input_clk),
    .rst       (rst),
    .clr       (start_ok),
    .inc       (run_inc && br_valid && br_miss),
    .q         (BranchPredictionMissCount)
  );
`else
  logic unused_br;
  assign unused_br                 = br_valid ^ br_miss;
  assign BranchPredictionCount     = '0;
  assign BranchPredictionMissCount = '0;
`endif

endmodule
